// File: rtl/result_drain.sv
// Collects one row of per-column array results, then serialises the active
// lanes two per 32-bit word toward the write-back path under valid/ready.
module result_drain #(
  parameter int col        = 32,
  parameter int data_width = 16
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic [4:0]                       col_dim,
  input  logic [col-1:0][data_width-1:0]   result_in,
  input  logic [col-1:0]                   result_vld,
  output logic                             in_rdy,
  output logic [31:0]                      data_out,
  output logic                             out_vld,
  input  logic                             out_rdy,
  output logic                             row_done,
  output logic                             overflow
);

  typedef enum logic [1:0] {IDLE, COLLECT, SEND} state_t;

  state_t                 state_q, state_d;
  logic [data_width-1:0]  lane_q [col];
  logic [data_width-1:0]  lane_d [col];
  logic [col-1:0]         mask_q, mask_d;
  logic [5:0]             activeN_q, activeN_d;
  logic [4:0]             k_q, k_d;
  logic [31:0]            data_q, data_d;
  logic                   outVld_q, outVld_d;
  logic                   rowDone_q, rowDone_d;
  logic                   overflow_q, overflow_d;

  logic [5:0]             clampN, activeCnt, wordCnt;
  logic [col-1:0]         activeMask, capVec, newMask;
  logic                   rowFull, accept, lastWord;
  logic [31:0]            words [col/2];

  // Before the first capture the width comes live from col_dim; afterwards the latched value rules.
  assign clampN    = ({1'b0, col_dim} + 6'd1 > 6'(col)) ? 6'(col) : {1'b0, col_dim} + 6'd1;
  assign activeCnt = (state_q == IDLE) ? clampN : activeN_q;

  always_comb begin
    for (int i = 0; i < col; i++) begin
      activeMask[i] = (6'(i) < activeCnt);
    end
  end

  assign capVec   = (state_q != SEND) ? (result_vld & activeMask) : '0;
  assign newMask  = mask_q | capVec;
  assign rowFull  = ((newMask & activeMask) == activeMask) && (state_q != SEND);
  assign wordCnt  = (activeN_q + 6'd1) >> 1;
  assign accept   = outVld_q && out_rdy;
  assign lastWord = ({1'b0, k_q} == wordCnt - 6'd1);

  always_ff @(posedge clk) begin
    if (rst) state_q <= IDLE;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (|capVec) state_d = rowFull ? SEND : COLLECT;
      COLLECT: if (rowFull) state_d = SEND;
      SEND:    if (accept && lastWord) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    in_rdy   = (state_q != SEND);
    data_out = data_q;
    out_vld  = outVld_q;
    row_done = rowDone_q;
    overflow = overflow_q;
  end

  always_comb begin
    lane_d     = lane_q;
    mask_d     = mask_q;
    activeN_d  = activeN_q;
    k_d        = k_q;
    overflow_d = overflow_q;
    rowDone_d  = 1'b0;
    data_d     = data_q;

    for (int i = 0; i < col; i++) begin
      if (capVec[i]) lane_d[i] = result_in[i];
    end
    if (state_q != SEND) mask_d = newMask;
    if (state_q == IDLE && |capVec) activeN_d = clampN;

    if (state_q == COLLECT && |(capVec & mask_q)) overflow_d = 1'b1;
    if (state_q == SEND && |(result_vld & activeMask)) overflow_d = 1'b1;

    if (accept) begin
      if (lastWord) begin
        k_d       = '0;
        mask_d    = '0;
        rowDone_d = 1'b1;
      end else begin
        k_d = k_q + 5'd1;
      end
    end

    // Words are built from next-cycle lanes so word 0 already holds the final capture.
    for (int w = 0; w < col/2; w++) begin
      words[w] = {(6'(2*w+1) < activeN_d) ? 16'(lane_d[2*w+1]) : 16'h0,
                  (6'(2*w)   < activeN_d) ? 16'(lane_d[2*w])   : 16'h0};
    end
    if (state_d == SEND) data_d = words[k_d];

    outVld_d = (state_d == SEND);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < col; i++) lane_q[i] <= '0;
      mask_q     <= '0;
      activeN_q  <= '0;
      k_q        <= '0;
      data_q     <= '0;
      outVld_q   <= 1'b0;
      rowDone_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      lane_q     <= lane_d;
      mask_q     <= mask_d;
      activeN_q  <= activeN_d;
      k_q        <= k_d;
      data_q     <= data_d;
      outVld_q   <= outVld_d;
      rowDone_q  <= rowDone_d;
      overflow_q <= overflow_d;
    end
  end

endmodule

// File: tb/tb_result_drain.sv
// Bench for result_drain: directed rows plus random traffic, all checked each
// cycle against a row/word-queue reference model.
module tb_result_drain;

  localparam int COL = 32;
  localparam int DW  = 16;

  logic                     clk = 1'b0;
  logic                     rst;
  logic [4:0]               colDim;
  logic [COL-1:0][DW-1:0]   resultIn;
  logic [COL-1:0]           resultVld;
  logic                     inRdy;
  logic [31:0]              dataOut;
  logic                     outVld;
  logic                     outRdy;
  logic                     rowDone;
  logic                     overflow;

  always #5 clk = ~clk;

  result_drain #(.col(COL), .data_width(DW)) dut (
    .clk        (clk),
    .rst        (rst),
    .col_dim    (colDim),
    .result_in  (resultIn),
    .result_vld (resultVld),
    .in_rdy     (inRdy),
    .data_out   (dataOut),
    .out_vld    (outVld),
    .out_rdy    (outRdy),
    .row_done   (rowDone),
    .overflow   (overflow)
  );

  int errors = 0;
  int checks = 0;

  // Reference model: a row of captured lanes, then a queue of words to emit.
  logic [15:0] mLanes [COL];
  bit          mCapt  [COL];
  int          mActive;
  bit          mStarted, mSending, mRowDone, mOverflow;
  logic [31:0] mWords [$];
  logic [31:0] gotWords [$];

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", tag, actual, expected);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < COL; i++) begin
      mLanes[i] = '0;
      mCapt[i]  = 1'b0;
    end
    mActive   = 0;
    mStarted  = 1'b0;
    mSending  = 1'b0;
    mRowDone  = 1'b0;
    mOverflow = 1'b0;
    mWords.delete();
  endtask

  task automatic modelStep();
    int act;
    bit any;
    bit all;
    logic [15:0] hi;
    if (rst) begin
      modelReset();
      return;
    end
    mRowDone = 1'b0;
    if (mSending) begin
      for (int i = 0; i < mActive; i++) if (resultVld[i]) mOverflow = 1'b1;
      if (outRdy) begin
        void'(mWords.pop_front());
        if (mWords.size() == 0) begin
          mSending = 1'b0;
          mStarted = 1'b0;
          for (int i = 0; i < COL; i++) mCapt[i] = 1'b0;
          mRowDone = 1'b1;
        end
      end
    end else begin
      act = mStarted ? mActive : ((int'(colDim) + 1 > COL) ? COL : int'(colDim) + 1);
      any = 1'b0;
      for (int i = 0; i < act; i++) begin
        if (resultVld[i]) begin
          if (mCapt[i]) mOverflow = 1'b1;
          mLanes[i] = resultIn[i];
          mCapt[i]  = 1'b1;
          any = 1'b1;
        end
      end
      if (any && !mStarted) begin
        mStarted = 1'b1;
        mActive  = act;
      end
      if (mStarted) begin
        all = 1'b1;
        for (int i = 0; i < mActive; i++) if (!mCapt[i]) all = 1'b0;
        if (all) begin
          for (int w = 0; w < (mActive + 1) / 2; w++) begin
            hi = (2*w + 1 < mActive) ? mLanes[2*w+1] : 16'h0;
            mWords.push_back({hi, mLanes[2*w]});
          end
          mSending = 1'b1;
        end
      end
    end
  endtask

  // One clock cycle: compare outputs with the model, then advance both across the edge.
  task automatic applyStimulus();
    checkOutput("outVld",   32'(outVld),   32'(mSending));
    checkOutput("inRdy",    32'(inRdy),    32'(!mSending));
    checkOutput("rowDone",  32'(rowDone),  32'(mRowDone));
    checkOutput("overflow", 32'(overflow), 32'(mOverflow));
    if (mSending) begin
      checkOutput("dataOut", dataOut, mWords[0]);
      if (outRdy) gotWords.push_back(dataOut);
    end
    modelStep();
    @(posedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst       = 1'b1;
    colDim    = '0;
    resultIn  = '0;
    resultVld = '0;
    outRdy    = 1'b0;
    modelReset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    checkOutput("resetData", dataOut, 32'h0);
    applyStimulus();
    rst = 1'b0;

    // Full row in a single cycle.
    colDim = 5'd31;
    for (int i = 0; i < COL; i++) resultIn[i] = 16'h0100 + 16'(i);
    resultVld = '1;
    outRdy    = 1'b1;
    gotWords.delete();
    applyStimulus();
    resultVld = '0;
    repeat (18) applyStimulus();
    checkOutput("fullCount", 32'(gotWords.size()), 32'd16);
    if (gotWords.size() == 16) begin
      checkOutput("fullWord0",  gotWords[0],  32'h0101_0100);
      checkOutput("fullWord15", gotWords[15], 32'h011F_011E);
    end

    // Staggered captures with noise on inactive columns and a mid-row col_dim change.
    colDim = 5'd3;
    gotWords.delete();
    for (int c = 0; c < 8; c++) begin
      resultVld = '0;
      resultVld[COL-1:4] = 28'($urandom);
      case (c)
        0: begin resultVld[0] = 1'b1; resultIn[0] = 16'hAAAA; end
        2: begin resultVld[1] = 1'b1; resultIn[1] = 16'hBBBB; end
        5: begin resultVld[2] = 1'b1; resultIn[2] = 16'hCCCC; end
        7: begin resultVld[3] = 1'b1; resultIn[3] = 16'hDDDD; end
        default: ;
      endcase
      applyStimulus();
      if (c == 0) colDim = 5'd31;
    end
    resultVld = '0;
    repeat (4) applyStimulus();
    checkOutput("stagCount", 32'(gotWords.size()), 32'd2);
    if (gotWords.size() == 2) begin
      checkOutput("stagWord0", gotWords[0], 32'hBBBB_AAAA);
      checkOutput("stagWord1", gotWords[1], 32'hDDDD_CCCC);
    end

    // Odd active width.
    colDim = 5'd4;
    gotWords.delete();
    for (int i = 0; i < 5; i++) resultIn[i] = 16'(i + 1);
    resultVld = 32'h1F;
    applyStimulus();
    resultVld = '0;
    repeat (5) applyStimulus();
    checkOutput("oddCount", 32'(gotWords.size()), 32'd3);
    if (gotWords.size() == 3) begin
      checkOutput("oddWord0", gotWords[0], 32'h0002_0001);
      checkOutput("oddWord1", gotWords[1], 32'h0004_0003);
      checkOutput("oddWord2", gotWords[2], 32'h0000_0005);
    end

    // Backpressure.
    colDim      = 5'd1;
    resultIn[0] = 16'h1234;
    resultIn[1] = 16'h5678;
    resultVld   = 32'h3;
    outRdy      = 1'b0;
    applyStimulus();
    resultVld = '0;
    repeat (5) applyStimulus();
    outRdy = 1'b1;
    repeat (3) applyStimulus();

    // Duplicate capture, then captures during SEND.
    colDim = 5'd3;
    gotWords.delete();
    resultVld = 32'h1; resultIn[0] = 16'd7;
    applyStimulus();
    resultIn[0] = 16'd9;
    applyStimulus();
    resultVld = 32'hE;
    for (int i = 1; i < 4; i++) resultIn[i] = 16'h0030 + 16'(i);
    applyStimulus();
    resultVld = '1;
    for (int i = 0; i < COL; i++) resultIn[i] = 16'hFFFF;
    outRdy = 1'b0;
    repeat (2) applyStimulus();
    resultVld = '0;
    outRdy = 1'b1;
    repeat (4) applyStimulus();
    checkOutput("dupOverflow", 32'(overflow), 32'd1);
    if (gotWords.size() == 2) checkOutput("dupLow", 32'(gotWords[0][15:0]), 32'd9);
    else checkOutput("dupCount", 32'(gotWords.size()), 32'd2);

    // Reset in the middle of SEND, then a clean full row.
    colDim = 5'd7;
    for (int i = 0; i < COL; i++) resultIn[i] = 16'($urandom);
    resultVld = 32'hFF;
    applyStimulus();
    resultVld = '0;
    applyStimulus();
    outRdy = 1'b0;
    rst = 1'b1;
    applyStimulus();
    rst = 1'b0;
    outRdy = 1'b1;
    applyStimulus();
    colDim = 5'd31;
    for (int i = 0; i < COL; i++) resultIn[i] = 16'($urandom);
    resultVld = '1;
    applyStimulus();
    resultVld = '0;
    repeat (18) applyStimulus();

    // Random traffic.
    for (int n = 0; n < 1500; n++) begin
      rst = ($urandom_range(0, 299) == 0);
      if ($urandom_range(0, 99) < 10) colDim = 5'($urandom);
      resultVld = $urandom & $urandom & $urandom;
      for (int i = 0; i < COL; i++) resultIn[i] = 16'($urandom);
      outRdy = ($urandom_range(0, 3) != 0);
      applyStimulus();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
